// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Definitions shared by the 7-segment scan controller and the LED7Seg
//   decoder: digit count, nibble type, scan-phase enum, the all-digits-off
//   select pattern and the leading-zero suppression rule.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        SCAN_BLANK = 1'b0,
        SCAN_SHOW  = 1'b1
    } scan_state_e;

    // Active-low digit select with every cathode released.
    localparam logic [NUM_DIGITS-1:0] ALL_OFF = 4'hF;

    // True when `digit` must stay dark: blanking enabled, not the rightmost
    // digit, and this digit plus every digit to its left holds zero.
    function automatic logic lz_suppress(input logic [15:0] value,
                                         input logic [1:0]  digit,
                                         input logic        lz_en);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (k >= int'(digit) && value[4*k +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        return lz_en && (digit != 2'd0) && upper_zero;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// ---------------------------------------------------------------------------
// seg7_slot_timer
//   Slot counter, digit index and BLANK/SHOW phase of the display scan.
//   All outputs are look-ahead: they describe the cycle that begins at the
//   next clock edge, so the parent can register its outputs in step with
//   the counter.
//
//   Ports
//     clk, rst_n  clock, asynchronous active-low reset
//     idx         digit index of the next cycle
//     in_show     next cycle is in the SHOW phase
//     slot_start  next cycle is the first BLANK cycle of a new slot
//     frame_end   the slot wrapping now is digit 3's (next cycle is digit 0)
// ---------------------------------------------------------------------------
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] idx,
    output logic       in_show,
    output logic       slot_start,
    output logic       frame_end
);

    localparam int                CNT_W    = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]  CNT_SHOW = CNT_W'(BLANK);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    scan_state_e      state_q, state_d;
    logic             wrap;

    // NOTE: every signal written in always_comb gets a default before any
    // branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        state_d = state_q;
        case (state_q)
            SCAN_BLANK: if (cnt_d == CNT_SHOW) state_d = SCAN_SHOW;
            SCAN_SHOW:  if (wrap)              state_d = SCAN_BLANK;
            default:                           state_d = SCAN_BLANK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            state_q <= SCAN_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    assign idx        = idx_d;
    assign in_show    = (state_d == SCAN_SHOW);
    assign slot_start = wrap;
    assign frame_end  = wrap && (idx_q == 2'd3);

endmodule

// File: rtl/seg7_scan_mux.sv
// ---------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexed scan controller for a 4-digit common-cathode display.
//   Presents one BCD nibble at a time to the LED7Seg decoder and drives the
//   matching active-low cathode, with a blank gap at the start of each slot.
//   Loaded values wait in a pending register and reach the display only at
//   a frame boundary, so a frame never mixes old and new digits.
//
//   Ports
//     clk, rst_n   clock, asynchronous active-low reset
//     value_in     packed BCD, [3:0] = digit 0 (rightmost)
//     load         one-cycle strobe capturing value_in into the pending reg
//     lz_en        leading-zero blanking enable
//     a, b, c, d   current nibble, a = MSB
//     dig_n        active-low digit select (at most one bit low)
//     frame_tick   one-cycle pulse on the first cycle of a new frame
// ---------------------------------------------------------------------------
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lz_en,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic [3:0]  dig_n,
    output logic        frame_tick
);

    logic [1:0] idx_nxt;
    logic       show_nxt;
    logic       slot_start;
    logic       frame_end;

    seg7_slot_timer #(
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx_nxt),
        .in_show    (show_nxt),
        .slot_start (slot_start),
        .frame_end  (frame_end)
    );

    logic [15:0] disp_q, disp_d;
    logic [15:0] pend_q;
    logic        pend_v_q;
    nibble_t     nib_q;
    logic [3:0]  dig_n_q;
    logic        frame_tick_q;
    logic        suppress_q, suppress_d;

    // The pending value is forwarded at the wrap edge itself so digit 0's
    // nibble register picks up the new frame's value on its first cycle.
    // Suppression is decided once per slot, from the value about to be shown
    // and lz_en as seen at the slot boundary.
    always_comb begin
        disp_d     = (frame_end && pend_v_q) ? pend_q : disp_q;
        suppress_d = suppress_q;
        if (slot_start) begin
            suppress_d = lz_suppress(disp_d, idx_nxt, lz_en);
        end
    end

    // NOTE: every register, including the display and pending values, is
    // cleared by reset so the first frame after release shows a known 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            nib_q        <= '0;
            dig_n_q      <= ALL_OFF;
            frame_tick_q <= 1'b0;
            suppress_q   <= 1'b0;
        end else begin
            disp_q     <= disp_d;
            suppress_q <= suppress_d;

            // A load coinciding with the wrap edge refills pend after the
            // old contents were transferred, so it waits a full frame.
            if (load) begin
                pend_q   <= value_in;
                pend_v_q <= 1'b1;
            end else if (frame_end) begin
                pend_v_q <= 1'b0;
            end

            if (slot_start) begin
                nib_q <= disp_d[int'(idx_nxt) * 4 +: 4];
            end

            dig_n_q      <= (show_nxt && !suppress_d) ? ~(4'b0001 << idx_nxt)
                                                      : ALL_OFF;
            frame_tick_q <= frame_end;
        end
    end

    assign {a, b, c, d} = nib_q;
    assign dig_n        = dig_n_q;
    assign frame_tick   = frame_tick_q;

endmodule
